// File: rtl/sram_like_bus_arbiter.sv
// Shares one SRAM-like slave port between the instruction and data masters, routing responses in order via a tag FIFO.
// Optional build macro SRAM_ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed data-over-inst priority.
module sram_like_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,

    output logic        busy,
    output logic        err
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD_I = 2'd1;
    localparam logic [1:0] HOLD_D = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       err_q, err_d;

    logic fifo_full;
    logic fifo_empty;
    logic head_tag;
    logic grant_valid;
    logic grant_tag;
    logic push;
    logic pop;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Tag of the master granted most recently; reset to inst so data wins the first tie.
    logic last_q, last_d;
`endif

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign head_tag   = tag_q[rd_ptr_q];

    // A held grant ignores the other master; a full FIFO blocks new grants even if it pops this cycle.
    always_comb begin
        grant_valid = 1'b0;
        grant_tag   = 1'b0;
        case (state_q)
            HOLD_I: begin
                grant_valid = 1'b1;
                grant_tag   = 1'b0;
            end
            HOLD_D: begin
                grant_valid = 1'b1;
                grant_tag   = 1'b1;
            end
            default: begin
                if (!fifo_full && (inst_req || data_req)) begin
                    grant_valid = 1'b1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    if (inst_req && data_req) begin
                        grant_tag = ~last_q;
                    end else begin
                        grant_tag = data_req;
                    end
`else
                    grant_tag = data_req;
`endif
                end
            end
        endcase
    end

    always_comb begin
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_size  = 2'd0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        if (grant_valid) begin
            bus_req = 1'b1;
            if (grant_tag) begin
                bus_wr    = data_wr;
                bus_size  = data_size;
                bus_addr  = data_addr;
                bus_wdata = data_wdata;
            end else begin
                bus_wr    = inst_wr;
                bus_size  = inst_size;
                bus_addr  = inst_addr;
                bus_wdata = inst_wdata;
            end
        end
    end

    assign push = grant_valid && bus_addr_ok;
    assign pop  = bus_data_ok && !fifo_empty;

    assign inst_addr_ok = push && !grant_tag;
    assign data_addr_ok = push && grant_tag;
    assign inst_data_ok = pop && !head_tag;
    assign data_data_ok = pop && head_tag;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    assign busy = !fifo_empty || (state_q != IDLE);
    assign err  = err_q;

    always_comb begin
        state_d = state_q;
        if (grant_valid) begin
            if (bus_addr_ok) begin
                state_d = IDLE;
            end else begin
                state_d = grant_tag ? HOLD_D : HOLD_I;
            end
        end
    end

    // Tag FIFO: push writes behind the current tail, so a simultaneous pop keeps order intact.
    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            tag_d[wr_ptr_q] = grant_tag;
            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        err_d = err_q || (bus_data_ok && fifo_empty);
    end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    always_comb begin
        last_d = push ? grant_tag : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

endmodule
